io_sched: RTL and testbench

Two-port scheduler for the I/O bus slave port of the PDS bus master. It arbitrates CPU-side (port A) and accelerator/DMA-side (port B) I/O requests and drives the single IOREQ/IOLDS/IOUDS/IOWE request onto the bus master. It selects which requester's address/data the external PDS latches capture, tracks completion through IOACT/IOBERR and returns per-port acknowledge or error. A watchdog aborts transfers whose bus cycle never terminates.

---
 rtl/io_sched.sv | 181 ++++++++++++++++++
 tb/tb_io_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_sched.sv
// io_sched: round-robin scheduler of two I/O requesters onto one PDS bus-master request,
// with a bus-cycle watchdog. Define IO_POSTWR_EN to post port-A writes (AACK issued with LATCH).
`timescale 1ns/1ps
module io_sched #(
    parameter logic [7:0] TO_CYC = 8'd200
) (
    input  logic c16m,
    input  logic nres,
    input  logic srst,
    input  logic areq,
    input  logic awe,
    input  logic alds,
    input  logic auds,
    input  logic breq,
    input  logic bwe,
    input  logic blds,
    input  logic buds,
    output logic aack,
    output logic aerr,
    output logic back,
    output logic berr,
    output logic iosel,
    output logic latch,
    output logic ioreq,
    output logic iolds,
    output logic iouds,
    output logic iowe,
    input  logic ioact,
    input  logic ioberr
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_REQ   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t     state_r;
    logic       prio_r;
    logic       seen_r;
    logic       post_r;
    logic [7:0] cnt_r;
    logic       iosel_r, latch_r, ioreq_r, iolds_r, iouds_r, iowe_r;
    logic       aack_r, aerr_r, back_r, berr_r;

    logic       win_s, win_we_s, win_lds_s, win_uds_s, post_s;

    // Winner selection: prio_r names the port that wins a tie (0 = A)
    always_comb begin
        win_s     = 1'b0;
        win_we_s  = 1'b0;
        win_lds_s = 1'b0;
        win_uds_s = 1'b0;
        post_s    = 1'b0;
        if (areq && (!breq || !prio_r)) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
        if (win_s) begin
            win_we_s  = bwe;
            win_lds_s = blds;
            win_uds_s = buds;
        end else begin
            win_we_s  = awe;
            win_lds_s = alds;
            win_uds_s = auds;
        end
`ifdef IO_POSTWR_EN
        post_s = ~win_s & awe;
`else
        post_s = 1'b0;
`endif
    end

    // Scheduler FSM; all bus-side and requester-side outputs are registered here
    always_ff @(posedge c16m or negedge nres) begin
        if (!nres) begin
            state_r <= S_IDLE;
            prio_r  <= 1'b0;
            seen_r  <= 1'b0;
            post_r  <= 1'b0;
            cnt_r   <= 8'd0;
            iosel_r <= 1'b0;
            latch_r <= 1'b0;
            ioreq_r <= 1'b0;
            iolds_r <= 1'b0;
            iouds_r <= 1'b0;
            iowe_r  <= 1'b0;
            aack_r  <= 1'b0;
            aerr_r  <= 1'b0;
            back_r  <= 1'b0;
            berr_r  <= 1'b0;
        end else if (srst) begin
            state_r <= S_IDLE;
            prio_r  <= 1'b0;
            seen_r  <= 1'b0;
            post_r  <= 1'b0;
            cnt_r   <= 8'd0;
            iosel_r <= 1'b0;
            latch_r <= 1'b0;
            ioreq_r <= 1'b0;
            iolds_r <= 1'b0;
            iouds_r <= 1'b0;
            iowe_r  <= 1'b0;
            aack_r  <= 1'b0;
            aerr_r  <= 1'b0;
            back_r  <= 1'b0;
            berr_r  <= 1'b0;
        end else begin
            latch_r <= 1'b0;
            aack_r  <= 1'b0;
            aerr_r  <= 1'b0;
            back_r  <= 1'b0;
            berr_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (areq || breq) begin
                        iosel_r <= win_s;
                        iowe_r  <= win_we_s;
                        iolds_r <= win_lds_s;
                        iouds_r <= win_uds_s;
                        prio_r  <= ~win_s;
                        latch_r <= 1'b1;
                        aack_r  <= post_s;
                        post_r  <= post_s;
                        state_r <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    ioreq_r <= 1'b1;
                    seen_r  <= 1'b0;
                    cnt_r   <= 8'd0;
                    state_r <= S_REQ;
                end
                S_REQ: begin
                    if (!ioact && seen_r) begin
                        ioreq_r <= 1'b0;
                        state_r <= S_IDLE;
                        // a posted write only reports a failed completion
                        if (ioberr) begin
                            aerr_r <= ~iosel_r;
                            berr_r <= iosel_r;
                        end else if (!post_r) begin
                            aack_r <= ~iosel_r;
                            back_r <= iosel_r;
                        end
                    end else if (cnt_r == TO_CYC - 8'd1) begin
                        ioreq_r <= 1'b0;
                        aerr_r  <= ~iosel_r;
                        berr_r  <= iosel_r;
                        state_r <= S_DRAIN;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                        if (ioact) begin
                            seen_r <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!ioact) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign aack  = aack_r;
    assign aerr  = aerr_r;
    assign back  = back_r;
    assign berr  = berr_r;
    assign iosel = iosel_r;
    assign latch = latch_r;
    assign ioreq = ioreq_r;
    assign iolds = iolds_r;
    assign iouds = iouds_r;
    assign iowe  = iowe_r;

endmodule

// File: tb/tb_io_sched.sv
// Bench for io_sched: directed protocol scenarios plus randomized requesters and bus master,
// all checked every cycle against a timestamp-based transaction model.
`timescale 1ns/1ps
module tb_io_sched;
    localparam logic [7:0] TO_CYC = 8'd200;
    localparam int TO_INT = 200;

    logic c16m = 1'b0;
    logic nres = 1'b0, srst = 1'b0;
    logic areq = 1'b0, awe = 1'b0, alds = 1'b0, auds = 1'b0;
    logic breq = 1'b0, bwe = 1'b0, blds = 1'b0, buds = 1'b0;
    logic ioact = 1'b0, ioberr = 1'b0;
    logic aack, aerr, back, berr, iosel, latch, ioreq, iolds, iouds, iowe;
    logic [9:0] outs;

    io_sched #(.TO_CYC(TO_CYC)) dut (
        .c16m(c16m), .nres(nres), .srst(srst),
        .areq(areq), .awe(awe), .alds(alds), .auds(auds),
        .breq(breq), .bwe(bwe), .blds(blds), .buds(buds),
        .aack(aack), .aerr(aerr), .back(back), .berr(berr),
        .iosel(iosel), .latch(latch), .ioreq(ioreq),
        .iolds(iolds), .iouds(iouds), .iowe(iowe),
        .ioact(ioact), .ioberr(ioberr)
    );

    always #5 c16m = ~c16m;
    assign outs = {aack, aerr, back, berr, iosel, latch, ioreq, iolds, iouds, iowe};

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // transaction model: one transfer in flight, described by its grant edge m_tg
    logic m_busy, m_port, m_seen, m_drain, m_post, m_prio;
    int   m_tg;
    logic e_aack, e_aerr, e_back, e_berr, e_iosel, e_latch, e_ioreq, e_lds, e_uds, e_we;

    // stimulus agents
    logic auto_bm = 1'b0, auto_rq = 1'b0;
    int   bm_ph = 0, bm_cnt = 0, rq_pct = 0;
    logic rq_lvl[2], pend[2], rq_we[2], rq_lds[2], rq_uds[2];

    task automatic model_reset();
        m_busy = 0; m_port = 0; m_seen = 0; m_drain = 0; m_post = 0; m_prio = 0; m_tg = 0;
        e_aack = 0; e_aerr = 0; e_back = 0; e_berr = 0; e_iosel = 0;
        e_latch = 0; e_ioreq = 0; e_lds = 0; e_uds = 0; e_we = 0;
    endtask

    task automatic model_resp(input logic port, input logic is_err);
        if (is_err) begin
            if (port) e_berr = 1; else e_aerr = 1;
        end else begin
            if (port) e_back = 1; else e_aack = 1;
        end
    endtask

    task automatic model_step();
        if (!nres || srst) begin
            model_reset();
            return;
        end
        e_aack = 0; e_aerr = 0; e_back = 0; e_berr = 0; e_latch = 0;
        if (!m_busy) begin
            if (areq || breq) begin
                m_port  = (areq && breq) ? m_prio : breq;
                m_prio  = ~m_port;
                m_tg    = cyc;
                m_busy  = 1; m_seen = 0; m_drain = 0; m_post = 0;
                e_latch = 1;
                e_iosel = m_port;
                e_we    = m_port ? bwe  : awe;
                e_lds   = m_port ? blds : alds;
                e_uds   = m_port ? buds : auds;
`ifdef IO_POSTWR_EN
                if (!m_port && awe) begin
                    m_post = 1;
                    e_aack = 1;
                end
`endif
            end
        end else if (m_drain) begin
            if (!ioact) begin
                m_busy = 0; m_drain = 0;
            end
        end else if (cyc == m_tg + 1) begin
            e_ioreq = 1;
        end else if (!ioact && m_seen) begin
            e_ioreq = 0; m_busy = 0;
            if (ioberr) model_resp(m_port, 1'b1);
            else if (!m_post) model_resp(m_port, 1'b0);
        end else if (cyc == m_tg + 1 + TO_INT) begin
            e_ioreq = 0; m_drain = 1;
            model_resp(m_port, 1'b1);
        end else if (ioact) begin
            m_seen = 1;
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [9:0] got, input logic [9:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    task automatic drive_req();
        areq = rq_lvl[0]; awe = rq_we[0]; alds = rq_lds[0]; auds = rq_uds[0];
        breq = rq_lvl[1]; bwe = rq_we[1]; blds = rq_lds[1]; buds = rq_uds[1];
    endtask

    task automatic bus_emul();
        case (bm_ph)
            0: if (ioreq) begin bm_cnt = $urandom_range(0, 3); bm_ph = 1; end
            1: begin
                if (bm_cnt == 0) begin
                    ioact  = 1'b1;
                    bm_cnt = ($urandom_range(0, 29) == 0) ? $urandom_range(205, 230) : $urandom_range(0, 11);
                    bm_ph  = 2;
                end else bm_cnt--;
            end
            2: begin
                if (bm_cnt == 0) begin
                    ioact  = 1'b0;
                    ioberr = ($urandom_range(0, 3) == 0);
                    bm_ph  = 3;
                end else bm_cnt--;
            end
            default: begin
                ioberr = 1'b0;
                if (!ioreq) bm_ph = 0;
            end
        endcase
    endtask

    task automatic req_emul();
        logic resp;
        for (int p = 0; p < 2; p++) begin
            resp = (p == 1) ? (back | berr) : (aack | aerr);
            if (latch && (iosel == p[0])) pend[p] = 1'b1;
            if (resp) pend[p] = 1'b0;
            if (rq_lvl[p]) begin
                if (resp) rq_lvl[p] = 1'b0;
                else if (pend[p] && $urandom_range(0, 7) == 0) rq_lvl[p] = 1'b0;
            end else if (!pend[p] && $urandom_range(0, 99) < rq_pct) begin
                rq_lvl[p] = 1'b1;
                rq_we[p]  = $urandom_range(0, 1);
                rq_lds[p] = $urandom_range(0, 1);
                rq_uds[p] = $urandom_range(0, 1);
            end
        end
        drive_req();
    endtask

    // one clock: model at the edge, compare and re-drive at the falling edge
    task automatic cycle();
        @(posedge c16m);
        cyc++;
        model_step();
        @(negedge c16m);
        chkv("outputs", outs, {e_aack, e_aerr, e_back, e_berr, e_iosel, e_latch, e_ioreq, e_lds, e_uds, e_we});
        if (auto_bm) bus_emul();
        if (auto_rq) req_emul();
    endtask

    task automatic quiesce();
        logic done;
        done = 1'b0;
        rq_pct = 0;
        for (int i = 0; i < 800 && !done; i++) begin
            cycle();
            done = !rq_lvl[0] && !rq_lvl[1] && !m_busy && bm_ph == 0 && !ioact;
        end
        chk1("quiesce_done", done, 1'b1);
        auto_bm = 0; auto_rq = 0;
        ioact = 0; ioberr = 0;
        for (int p = 0; p < 2; p++) begin rq_lvl[p] = 0; pend[p] = 0; end
        drive_req();
        cycle();
    endtask

    // grant already latched for port A: run a short clean bus cycle and expect AACK
    task automatic finish_a(input string name);
        cycle();
        chk1({name, "_ioreq"}, ioreq, 1'b1);
        ioact = 1'b1;
        cycle();
        ioact = 1'b0;
        cycle();
        chk1({name, "_aack"}, aack, 1'b1);
        areq = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int g[3];
        int ng, n_ack, n_err, n_bad, k;
        model_reset();
        for (int p = 0; p < 2; p++) begin
            rq_lvl[p] = 0; pend[p] = 0; rq_we[p] = 0; rq_lds[p] = 0; rq_uds[p] = 0;
        end

        // reset values, both ports requesting across reset release
        areq = 1; breq = 1; alds = 1; blds = 1;
        repeat (3) @(negedge c16m);
        chkv("reset_outs", outs, 10'b0);
        nres = 1'b1;
        rq_lvl[0] = 1; rq_lvl[1] = 1; rq_lds[0] = 1; rq_lds[1] = 1;
        rq_pct = 100; auto_bm = 1; auto_rq = 1; bm_ph = 0;
        g = '{-1, -1, -1};
        ng = 0;
        for (int i = 0; i < 600 && ng < 3; i++) begin
            cycle();
            if (latch) begin g[ng] = int'(iosel); ng++; end
        end
        chki("rr_grant_count", ng, 3);
        chki("rr_first_A", g[0], 0);
        chki("rr_then_B", g[1], 1);
        chki("rr_then_A", g[2], 0);
        quiesce();

        // port A read with a 10-cycle bus cycle
        areq = 1; awe = 0; alds = 1; auds = 0;
        cycle();
        chk1("a_rd_latch_t1", latch, 1'b1);
        chk1("a_rd_iosel", iosel, 1'b0);
        chk1("a_rd_noreq_t1", ioreq, 1'b0);
        cycle();
        chk1("a_rd_ioreq_t2", ioreq, 1'b1);
        ioact = 1;
        repeat (10) cycle();
        ioact = 0;
        n_ack = 0; n_bad = 0;
        repeat (6) begin
            cycle();
            if (aack) begin n_ack++; areq = 0; end
            if (iowe || aerr || back || berr) n_bad++;
        end
        chki("a_rd_aack_once", n_ack, 1);
        chki("a_rd_no_other", n_bad, 0);

        // port B write ending in a bus error
        breq = 1; bwe = 1; blds = 1; buds = 1;
        cycle(); cycle();
        ioact = 1;
        n_bad = 0;
        repeat (5) begin cycle(); if (ioreq && !iowe) n_bad++; end
        ioact = 0; ioberr = 1;
        n_ack = 0; n_err = 0;
        repeat (6) begin
            cycle();
            ioberr = 0;
            if (ioreq && !iowe) n_bad++;
            if (berr) begin n_err++; breq = 0; end
            if (back) n_ack++;
        end
        chki("b_wr_berr_once", n_err, 1);
        chki("b_wr_no_back", n_ack, 0);
        chki("b_wr_iowe_held", n_bad, 0);

        // watchdog: IOACT never falls
        breq = 1; bwe = 0;
        cycle(); cycle();
        ioact = 1;
        k = 0;
        for (int i = 0; i < 260; i++) begin
            cycle(); k++;
            if (berr) break;
        end
        chki("to_berr_delay", k, TO_INT);
        chk1("to_ioreq_dropped", ioreq, 1'b0);
        breq = 0; areq = 1; awe = 0;
        n_bad = 0;
        repeat (20) begin cycle(); if (latch) n_bad++; end
        chki("to_no_grant_in_drain", n_bad, 0);
        ioact = 0;
        cycle();
        chk1("to_drain_exit_nolatch", latch, 1'b0);
        cycle();
        chk1("to_regrant_latch", latch, 1'b1);
        finish_a("to_after");

        // asynchronous reset in the middle of a bus cycle
        areq = 1;
        cycle(); cycle();
        ioact = 1;
        cycle();
        #2 nres = 1'b0;
        #1 chkv("async_rst_outs", outs, 10'b0);
        model_reset();
        ioact = 0;
        @(negedge c16m);
        nres = 1'b1;
        cycle();
        chk1("rst_restart_latch", latch, 1'b1);
        finish_a("rst_restart");

        // synchronous soft reset while the request is outstanding
        areq = 1;
        cycle(); cycle();
        srst = 1;
        cycle();
        chk1("srst_ioreq", ioreq, 1'b0);
        srst = 0;
        cycle();
        chk1("srst_restart_latch", latch, 1'b1);
        finish_a("srst_restart");

`ifdef IO_POSTWR_EN
        // posted port-A writes
        areq = 1; awe = 1;
        cycle();
        chk1("pw_latch", latch, 1'b1);
        chk1("pw_early_aack", aack, 1'b1);
        areq = 0;
        cycle();
        areq = 1; awe = 1;
        ioact = 1;
        n_bad = 0;
        repeat (5) begin cycle(); if (latch) n_bad++; end
        chki("pw_second_waits", n_bad, 0);
        ioact = 0;
        cycle();
        chk1("pw_no_late_aack", aack, 1'b0);
        cycle();
        chk1("pw_second_latch", latch, 1'b1);
        chk1("pw_second_aack", aack, 1'b1);
        areq = 0;
        cycle();
        ioact = 1;
        cycle();
        ioact = 0;
        cycle(); cycle();
`endif

        // randomized traffic from both ports against a random bus master
        for (int p = 0; p < 2; p++) begin rq_lvl[p] = 0; pend[p] = 0; end
        bm_ph = 0; rq_pct = 30; auto_bm = 1; auto_rq = 1;
        repeat (4000) cycle();
        quiesce();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
